baud_clock_gen: RTL

//  Parametrised UART baud/oversample timing generator; successor to the fixed 16x transfer clock gen.

---
 rtl/baud_clock_gen.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/baud_clock_gen.sv
// UART baud/oversample timing generator: independent RX and TX dividers with oversample phase counters.
// Optional fractional divider enabled by defining UART_FRAC_DIV_EN.

module baud_div_side #(
    parameter int DIV_W  = 16,
    parameter int OSR    = 16,
    parameter int FRAC_W = 4,
    parameter int PH_W   = $clog2(OSR)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [FRAC_W-1:0] frac_i,
    output logic              term_o,
    output logic [PH_W-1:0]   ph_next_o
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] sdiv_q, sdiv_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic             idle;
    logic             at_end;
    logic             stall;

`ifdef UART_FRAC_DIV_EN
    logic [FRAC_W-1:0] sfrac_q, sfrac_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0]   acc_sum;
    logic              ext_q, ext_d;

    assign acc_sum = {1'b0, acc_q} + {1'b0, sfrac_q};
    // A carried period is stretched by holding one extra cycle at the terminal count.
    assign stall   = ext_q;
`else
    logic unused_frac;
    assign unused_frac = ^frac_i;
    assign stall       = 1'b0;
`endif

    // A zero shadow means no legal divisor yet: keep re-sampling until one appears.
    assign idle      = (sdiv_q == '0);
    assign at_end    = !idle && (cnt_q == sdiv_q);
    assign term_o    = en_i && at_end && !stall && !clr_i;
    assign ph_next_o = (ph_q == PH_W'(OSR - 1)) ? '0 : ph_q + PH_W'(1);

    always_comb begin
        cnt_d  = cnt_q;
        sdiv_d = sdiv_q;
        ph_d   = ph_q;
`ifdef UART_FRAC_DIV_EN
        sfrac_d = sfrac_q;
        acc_d   = acc_q;
        ext_d   = ext_q;
`endif
        if (clr_i) begin
            cnt_d  = DIV_W'(1);
            ph_d   = '0;
            sdiv_d = div_i;
`ifdef UART_FRAC_DIV_EN
            sfrac_d = frac_i;
            acc_d   = '0;
            ext_d   = 1'b0;
`endif
        end else if (idle) begin
            cnt_d  = DIV_W'(1);
            sdiv_d = div_i;
`ifdef UART_FRAC_DIV_EN
            sfrac_d = frac_i;
`endif
        end else if (term_o) begin
            cnt_d  = DIV_W'(1);
            ph_d   = ph_next_o;
            sdiv_d = div_i;
`ifdef UART_FRAC_DIV_EN
            sfrac_d = frac_i;
            acc_d   = acc_sum[FRAC_W-1:0];
            ext_d   = acc_sum[FRAC_W];
`endif
        end else if (en_i && !at_end) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
`ifdef UART_FRAC_DIV_EN
        if (!clr_i && en_i && at_end && ext_q) begin
            ext_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= DIV_W'(1);
            sdiv_q <= '0;
            ph_q   <= '0;
`ifdef UART_FRAC_DIV_EN
            sfrac_q <= '0;
            acc_q   <= '0;
            ext_q   <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            sdiv_q <= sdiv_d;
            ph_q   <= ph_d;
`ifdef UART_FRAC_DIV_EN
            sfrac_q <= sfrac_d;
            acc_q   <= acc_d;
            ext_q   <= ext_d;
`endif
        end
    end
endmodule

module baud_clock_gen #(
    parameter int DIV_W  = 16,
    parameter int OSR    = 16,
    parameter int FRAC_W = 4
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  divisor,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              rx_clr,
    input  logic              tx_clr,
    output logic              rx_os_tick,
    output logic              voting_edge,
    output logic              sample_edge,
    output logic              transmit_edge,
    output logic              div_err
);
    localparam int PH_W = $clog2(OSR);
    localparam logic [PH_W-1:0] PH_VOTE_LO = PH_W'(OSR / 2 - 1);
    localparam logic [PH_W-1:0] PH_VOTE_HI = PH_W'(OSR / 2 + 1);
    localparam logic [PH_W-1:0] PH_SAMPLE  = PH_W'(OSR / 2 + 2);

    logic            rx_term, tx_term;
    logic [PH_W-1:0] rx_ph_next, tx_ph_next;

    logic rx_tick_q, rx_tick_d;
    logic vote_q, vote_d;
    logic sample_q, sample_d;
    logic tx_edge_q, tx_edge_d;
    logic err_q, err_d;

    baud_div_side #(.DIV_W(DIV_W), .OSR(OSR), .FRAC_W(FRAC_W), .PH_W(PH_W)) u_rx (
        .clk_i     (pclk),
        .rst_i     (preset),
        .en_i      (enable),
        .clr_i     (rx_clr),
        .div_i     (divisor),
        .frac_i    (div_frac),
        .term_o    (rx_term),
        .ph_next_o (rx_ph_next)
    );

    baud_div_side #(.DIV_W(DIV_W), .OSR(OSR), .FRAC_W(FRAC_W), .PH_W(PH_W)) u_tx (
        .clk_i     (pclk),
        .rst_i     (preset),
        .en_i      (enable),
        .clr_i     (tx_clr),
        .div_i     (divisor),
        .frac_i    (div_frac),
        .term_o    (tx_term),
        .ph_next_o (tx_ph_next)
    );

    // Strobes are decoded from the phase each terminal moves into.
    assign rx_tick_d = rx_term;
    assign vote_d    = rx_term && (rx_ph_next >= PH_VOTE_LO) && (rx_ph_next <= PH_VOTE_HI);
    assign sample_d  = rx_term && (rx_ph_next == PH_SAMPLE);
    assign tx_edge_d = tx_term && (tx_ph_next == '0);
    assign err_d     = enable && (divisor == '0);

    always_ff @(posedge pclk) begin
        if (preset) begin
            rx_tick_q <= 1'b0;
            vote_q    <= 1'b0;
            sample_q  <= 1'b0;
            tx_edge_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_tick_q <= rx_tick_d;
            vote_q    <= vote_d;
            sample_q  <= sample_d;
            tx_edge_q <= tx_edge_d;
            err_q     <= err_d;
        end
    end

    assign rx_os_tick    = rx_tick_q;
    assign voting_edge   = vote_q;
    assign sample_edge   = sample_q;
    assign transmit_edge = tx_edge_q;
    assign div_err       = err_q;
endmodule
